// File: rtl/ram_sdp_be_init_if.sv
// Bus bundle for ram_sdp_be_init: write port with lane enables, read port, and read/status returns.
// master drives requests; slave is the RAM side.
interface ram_sdp_be_init_if #(
  parameter int unsigned DATA_WIDTH = 288,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned LANE_W     = 8
) ();
  localparam int unsigned NLANE = DATA_WIDTH / LANE_W;

  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NLANE-1:0]      wbe;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;
  logic                  init_done;

  modport master (
    output wen, waddr, wdata, wbe, ren, raddr,
    input  q, q_valid, init_done
  );

  modport slave (
    input  wen, waddr, wdata, wbe, ren, raddr,
    output q, q_valid, init_done
  );
endinterface

// File: rtl/ram_sdp_be_init.sv
// Simple-dual-port RAM with lane write enables, post-reset clear sequencer and write-first bypass.
// Define RAM_OUT_REG_EN to add a second output register (read latency 2 instead of 1).
module ram_sdp_be_init #(
  parameter int unsigned DATA_WIDTH     = 288,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned LANE_W         = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  ram_sdp_be_init_if.slave bus
);
  localparam int unsigned NLANE = DATA_WIDTH / LANE_W;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_next;
  logic                  init_done_r;

  logic                  rd_acc_c;
  logic                  wr_en_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [NLANE-1:0]      wr_be_c;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_old_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic                  hit_c;

  logic [DATA_WIDTH-1:0] q1;
  logic                  v1;

  // Sequencer state register; init_done tracks the state the FSM is entering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_CLEAR;
      cnt         <= '0;
      init_done_r <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      init_done_r <= (state_next == ST_READY);
    end
  end

  // Next state plus selection of the single write port between clear sweep and user writes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rd_acc_c   = 1'b0;
    wr_en_c    = 1'b0;
    wr_addr_c  = bus.waddr;
    wr_data_c  = bus.wdata;
    wr_be_c    = bus.wbe;
    case (state)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET) begin
          wr_en_c   = 1'b1;
          wr_addr_c = cnt;
          wr_data_c = '0;
          wr_be_c   = '1;
          cnt_next  = cnt + ADDR_WIDTH'(1);
          if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state_next = ST_READY;
          end
        end else begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        wr_en_c  = bus.wen && (|bus.wbe);
        rd_acc_c = bus.ren;
      end
      default: begin
        state_next = ST_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // Array write, one lane at a time so lane-masked writes map onto byte-write RAM macros.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int unsigned i = 0; i < NLANE; i++) begin
        if (wr_be_c[i]) begin
          mem[wr_addr_c][i*LANE_W +: LANE_W] <= wr_data_c[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Write-first merge: on an address collision the enabled lanes come from wdata.
  always_comb begin
    rd_old_c  = mem[bus.raddr];
    hit_c     = wr_en_c && (state == ST_READY) && (bus.raddr == bus.waddr);
    rd_word_c = rd_old_c;
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (hit_c && bus.wbe[i]) begin
        rd_word_c[i*LANE_W +: LANE_W] = bus.wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // First read stage; q holds between completed reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd_acc_c;
      if (rd_acc_c) begin
        q1 <= rd_word_c;
      end
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] q2;
  logic                  v2;

  // Optional output register; only loads on a valid first-stage result so q still holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q2 <= '0;
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        q2 <= q1;
      end
    end
  end

  assign bus.q       = q2;
  assign bus.q_valid = v2;
`else
  assign bus.q       = q1;
  assign bus.q_valid = v1;
`endif

  assign bus.init_done = init_done_r;

endmodule
